// File: rtl/imem_loadable.sv
`timescale 1ns/1ps
// imem_loadable
//   Instruction memory with a registered, stallable fetch port and a byte-stream
//   loader that writes a new program image at run time.
//
//   Ports
//     clk, reset_n   rising-edge clock, asynchronous active-low reset
//     addr, rd_en    fetch word index and fetch enable (rd_en low = stall)
//     q, q_valid     registered instruction and "fetched last cycle" flag
//     start_load     enter LOAD (sampled only in RUN)
//     ld_valid/ld_ready/ld_data/ld_last
//                    loader beat handshake; beats are little-endian within a word
//     ld_done        one-cycle pulse when the load completes
//     loaded_words   words written by the last or current load
//     busy           high while loading
module imem_loadable #(
    parameter int N     = 32,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH),
    parameter int BW    = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] addr,
    input  logic          rd_en,
    output logic [N-1:0]  q,
    output logic          q_valid,
    input  logic          start_load,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [BW-1:0] ld_data,
    input  logic          ld_last,
    output logic          ld_done,
    output logic [AW:0]   loaded_words,
    output logic          busy
);

    localparam int NB  = N / BW;                      // beats per word
    localparam int BCW = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [BCW-1:0] LAST_BEAT = BCW'(NB - 1);
    localparam logic [AW-1:0]  LAST_WORD = AW'(DEPTH - 1);
    localparam logic [AW:0]    DEPTH_W   = (AW + 1)'(DEPTH);

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   wptr;
    logic [BCW-1:0]  beat;
    logic [N-1:0]    shift_word;
    logic [N-1:0]    asm_word;
    logic            accept;
    logic            word_end;
    logic            load_end;
    logic            addr_ok;

    logic [N-1:0]    mem [DEPTH];

    // NOTE: every signal assigned in an always_comb gets a default at the top of
    // the block, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        ld_ready  = (state == LOAD);
        busy      = (state == LOAD);
        accept    = ld_ready && ld_valid;
        word_end  = accept && (ld_last || (beat == LAST_BEAT));
        load_end  = word_end && (ld_last || (wptr == LAST_WORD));
        addr_ok   = ({1'b0, addr} < DEPTH_W);

        // Upper beats of shift_word are still zero (cleared after every write),
        // so a word closed early by ld_last comes out zero-filled.
        asm_word  = shift_word;
        asm_word[int'(beat)*BW +: BW] = ld_data;

        state_nxt = state;
        case (state)
            RUN:  if (start_load) state_nxt = LOAD;
            LOAD: if (load_end)   state_nxt = RUN;
            default:              state_nxt = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= RUN;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q            <= '0;
            q_valid      <= 1'b0;
            ld_done      <= 1'b0;
            loaded_words <= '0;
            wptr         <= '0;
            beat         <= '0;
            shift_word   <= '0;
        end else begin
            ld_done <= 1'b0;
            case (state)
                RUN: begin
                    if (rd_en) begin
                        q       <= addr_ok ? mem[addr] : '0;
                        q_valid <= 1'b1;
                    end else begin
                        q_valid <= 1'b0;
                    end
                    // A fetch coincident with start_load still updates q,
                    // but it is not flagged valid since the next state is LOAD.
                    if (start_load) begin
                        wptr         <= '0;
                        beat         <= '0;
                        shift_word   <= '0;
                        loaded_words <= '0;
                        q_valid      <= 1'b0;
                    end
                end
                LOAD: begin
                    q_valid <= 1'b0;
                    if (accept) begin
                        if (word_end) begin
                            wptr         <= wptr + 1'b1;
                            loaded_words <= loaded_words + 1'b1;
                            beat         <= '0;
                            shift_word   <= '0;
                            ld_done      <= load_end;
                        end else begin
                            shift_word   <= asm_word;
                            beat         <= beat + 1'b1;
                        end
                    end
                end
                default: q_valid <= 1'b0;
            endcase
        end
    end

    // NOTE: the memory array has no reset; a reset-free write port keeps it
    // mappable to block RAM, and program contents survive a loader reset.
    always_ff @(posedge clk) begin
        if (word_end) mem[wptr] <= asm_word;
    end

endmodule
